// File: rtl/cnn_downsampling_avg_02.sv
// rtl/cnn_downsampling_avg_02.sv - 4x4 stride-4 signed average pooling over a channel-major pixel stream
module cnn_downsampling_avg_02 #(
   parameter int IMAGE_WIDTH  = 64,
   parameter int IMAGE_HEIGHT = 64,
   parameter int CHANNEL_NUM  = 7,
   parameter int DATA_WIDTH   = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valid_in,
   input  logic [DATA_WIDTH-1:0] pxl_in,
   output logic [DATA_WIDTH-1:0] pxl_out,
   output logic                  valid_out,
   output logic                  frame_done
);

   // One accumulator per horizontal block; 4 guard bits hold the sum of 16 pixels.
   localparam int BLK_N = IMAGE_WIDTH / 4;
   localparam int BX_W  = (BLK_N > 1) ? $clog2(BLK_N) : 1;
   // Column counter is sized so its upper bits are exactly the block index.
   localparam int COL_W = BX_W + 2;
   localparam int ROW_W = $clog2(IMAGE_HEIGHT);
   localparam int CH_W  = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
   localparam int ACC_W = DATA_WIDTH + 4;

   logic [COL_W-1:0]        col;
   logic [ROW_W-1:0]        row;
   logic [CH_W-1:0]         chan;
   logic [BX_W-1:0]         bx;
   logic                    col_last;
   logic                    row_last;
   logic                    chan_last;
   logic                    blk_start;
   logic                    blk_end;
   logic signed [ACC_W-1:0] acc [BLK_N];
   logic signed [ACC_W-1:0] pxl_ext;
   logic signed [ACC_W-1:0] acc_sum;

   assign bx        = col[COL_W-1:2];
   assign col_last  = (col == COL_W'(IMAGE_WIDTH - 1));
   assign row_last  = (row == ROW_W'(IMAGE_HEIGHT - 1));
   assign chan_last = (chan == CH_W'(CHANNEL_NUM - 1));
   assign blk_start = (col[1:0] == 2'd0) && (row[1:0] == 2'd0);
   assign blk_end   = (col[1:0] == 2'd3) && (row[1:0] == 2'd3);
   assign pxl_ext   = {{4{pxl_in[DATA_WIDTH-1]}}, pxl_in};
   assign acc_sum   = acc[bx] + pxl_ext;

   // Position counters: col, then row, then channel; only accepted pixels advance them.
   always_ff @(posedge clk) begin
      if (reset) begin
         col  <= '0;
         row  <= '0;
         chan <= '0;
      end else if (valid_in) begin
         if (col_last) begin
            col <= '0;
            if (row_last) begin
               row  <= '0;
               chan <= chan_last ? '0 : chan + 1'b1;
            end else begin
               row <= row + 1'b1;
            end
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   // Block accumulators: first pixel of a block overwrites, the rest add; no reset needed.
   always_ff @(posedge clk) begin
      if (!reset && valid_in) begin
         acc[bx] <= blk_start ? pxl_ext : acc_sum;
      end
   end

   // Output register: on the 16th pixel emit sum/16; dropping the low 4 bits of the
   // signed sum is the arithmetic shift, i.e. floor toward negative infinity.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_out  <= 1'b0;
         frame_done <= 1'b0;
         pxl_out    <= '0;
      end else begin
         valid_out  <= valid_in && blk_end;
         frame_done <= valid_in && blk_end && col_last && row_last && chan_last;
         if (valid_in && blk_end) begin
            pxl_out <= acc_sum[ACC_W-1:4];
         end
      end
   end

endmodule

// File: tb/tb_cnn_downsampling_avg_02.sv
// tb/tb_cnn_downsampling_avg_02.sv - directed bench for cnn_downsampling_avg_02
module tb_cnn_downsampling_avg_02;

   localparam int W  = 8;
   localparam int H  = 8;
   localparam int C  = 2;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          valid_in = 1'b0;
   logic [DW-1:0] pxl_in = '0;
   logic [DW-1:0] pxl_out;
   logic          valid_out;
   logic          frame_done;

   int            n_vec = 0;
   int            n_err = 0;
   int            tb_col = 0;
   int            tb_row = 0;
   int            tb_chan = 0;
   int            out_cnt = 0;
   int            fd_cnt = 0;
   logic [DW-1:0] last_out = '0;

   always #5 clk = ~clk;

   cnn_downsampling_avg_02 #(
      .IMAGE_WIDTH (W),
      .IMAGE_HEIGHT(H),
      .CHANNEL_NUM (C),
      .DATA_WIDTH  (DW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .valid_in  (valid_in),
      .pxl_in    (pxl_in),
      .pxl_out   (pxl_out),
      .valid_out (valid_out),
      .frame_done(frame_done)
   );

   // Stimulus patterns: 0 const 16, 1 one -1 per block, 2 const -32, 3 ramp=col,
   // 4 max positive, 5 max negative.
   function automatic logic [DW-1:0] pix(input int mode, input int col, input int row);
      case (mode)
         0:       return 32'd16;
         1:       return ((col % 4 == 0) && (row % 4 == 0)) ? 32'hFFFF_FFFF : 32'd0;
         2:       return 32'hFFFF_FFE0;
         3:       return DW'(col);
         4:       return 32'h7FFF_FFFF;
         default: return 32'h8000_0000;
      endcase
   endfunction

   // Hand-computed block averages: ramp gives 24/16=1 and 88/16=5 after floor.
   function automatic logic [DW-1:0] exp_val(input int mode, input int bx);
      case (mode)
         0:       return 32'd16;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'hFFFF_FFE0;
         3:       return (bx == 0) ? 32'd1 : 32'd5;
         4:       return 32'h7FFF_FFFF;
         default: return 32'h8000_0000;
      endcase
   endfunction

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: drive on the falling edge, check registered outputs 1 time unit after the rising edge.
   task automatic clock_step(input logic v, input logic [DW-1:0] px, input int mode);
      logic          exp_v;
      logic          exp_fd;
      logic [DW-1:0] ev;
      @(negedge clk);
      valid_in = v;
      pxl_in   = px;
      @(posedge clk);
      #1;
      exp_v  = v && (tb_col % 4 == 3) && (tb_row % 4 == 3);
      exp_fd = exp_v && (tb_col == W - 1) && (tb_row == H - 1) && (tb_chan == C - 1);
      check("valid_out", DW'(valid_out), DW'(exp_v));
      check("frame_done", DW'(frame_done), DW'(exp_fd));
      if (exp_v) begin
         ev = exp_val(mode, tb_col / 4);
         check("pxl_out", pxl_out, ev);
         last_out = ev;
      end else begin
         check("pxl_hold", pxl_out, last_out);
      end
      if (valid_out) out_cnt++;
      if (frame_done) fd_cnt++;
      if (v) begin
         if (tb_col == W - 1) begin
            tb_col = 0;
            if (tb_row == H - 1) begin
               tb_row  = 0;
               tb_chan = (tb_chan == C - 1) ? 0 : tb_chan + 1;
            end else begin
               tb_row = tb_row + 1;
            end
         end else begin
            tb_col = tb_col + 1;
         end
      end
   endtask

   task automatic run_frame(input int mode, input bit gaps);
      out_cnt = 0;
      fd_cnt  = 0;
      for (int i = 0; i < W * H * C; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) clock_step(1'b0, 32'hDEAD_BEEF, mode);
         end
         clock_step(1'b1, pix(mode, tb_col, tb_row), mode);
      end
      check("out_count", DW'(out_cnt), DW'(W * H * C / 16));
      check("fd_count", DW'(fd_cnt), 32'd1);
   endtask

   // Reset for n cycles, optionally with a competing valid pixel that must be dropped.
   task automatic do_reset(input int n, input logic v);
      @(negedge clk);
      reset    = 1'b1;
      valid_in = v;
      pxl_in   = 32'h1234_5678;
      repeat (n) @(posedge clk);
      #1;
      check("rst_valid_out", DW'(valid_out), 32'd0);
      check("rst_frame_done", DW'(frame_done), 32'd0);
      check("rst_pxl_out", pxl_out, 32'd0);
      @(negedge clk);
      reset    = 1'b0;
      valid_in = 1'b0;
      tb_col   = 0;
      tb_row   = 0;
      tb_chan  = 0;
      last_out = '0;
   endtask

   initial begin
      do_reset(3, 1'b0);
      clock_step(1'b0, 32'd0, 0);

      run_frame(0, 1'b0);
      run_frame(1, 1'b0);
      run_frame(2, 1'b0);
      run_frame(3, 1'b0);
      run_frame(3, 1'b1);
      run_frame(4, 1'b0);
      run_frame(5, 1'b0);

      out_cnt = 0;
      repeat (20) clock_step(1'b1, pix(2, tb_col, tb_row), 2);
      check("partial_no_out", DW'(out_cnt), 32'd0);
      do_reset(1, 1'b1);
      run_frame(0, 1'b0);

      repeat (3) clock_step(1'b0, 32'd0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
